// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Provides the sequencer state enum, the nibble width and a helper that sizes the slice index.
// Contents: state_t, NIBBLE, idx_width().
package nsa_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width: clog2 of the slice count, never narrower than one bit.
    function automatic int idx_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla2.sv
// CLA2: 4-bit carry-lookahead slice driven from bitline compute results.
// Ports: bl (A&B per bit), blb (~(A|B) per bit), cin -> sum nibble, cout.
// Purely combinational; generate = BL, propagate = neither BL nor BLB set.
module nibble_serial_adder_cla2
    import nsa_pkg::*;
(
    input  logic [NIBBLE-1:0] bl,
    input  logic [NIBBLE-1:0] blb,
    input  logic              cin,
    output logic [NIBBLE-1:0] sum,
    output logic              cout
);

    logic [NIBBLE-1:0] g;
    logic [NIBBLE-1:0] p;
    logic [NIBBLE:0]   c;

    // With BL=A&B and BLB=~(A|B), a bit propagates exactly when A^B.
    assign g = bl;
    assign p = ~(bl | blb);

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[NIBBLE-1:0];
    assign cout = c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: accepts two WIDTH-bit operands, adds one nibble per cycle through
// a CLA2 slice with a registered carry, and returns {cout_o,sum_o} after WIDTH/4 cycles.
// Ports: clk/rst (async high), in_valid/in_ready/a_i/b_i/cin_i in, out_valid/out_ready/sum_o/cout_o out, busy_o.
// Optional: define NSA_SUBTRACT_EN to add sub_i (a - b via inverted B and forced carry-in).
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef NSA_SUBTRACT_EN
    input  logic             sub_i,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);

    localparam int NSLICE = WIDTH / NIBBLE;
    localparam int IW     = idx_width(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    generate
        if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
        end
    endgenerate

    state_t state_q, state_d;

    logic [NSLICE-1:0][NIBBLE-1:0] a_q, b_q, sum_q;
    logic                          carry_q;
    logic [IW-1:0]                 idx_q;

    logic accept, step;

    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef NSA_SUBTRACT_EN
    // Subtraction as a + ~b + 1: cin_i is irrelevant in that mode.
    assign b_load = sub_i ? ~b_i : b_i;
    assign c_load = sub_i ? 1'b1 : cin_i;
`else
    assign b_load = b_i;
    assign c_load = cin_i;
`endif

    // Bitline emulation for the current nibble.
    logic [NIBBLE-1:0] nib_a, nib_b, bl, blb, slice_sum;
    logic              slice_cout;

    assign nib_a = a_q[idx_q];
    assign nib_b = b_q[idx_q];
    assign bl    = nib_a & nib_b;
    assign blb   = ~(nib_a | nib_b);

    nibble_serial_adder_cla2 u_cla2 (
        .bl   (bl),
        .blb  (blb),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy_o    = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                step   = 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o    = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= b_load;
            sum_q   <= '0;
            carry_q <= c_load;
            idx_q   <= '0;
        end else if (step) begin
            sum_q[idx_q] <= slice_sum;
            carry_q      <= slice_cout;
            // Index parks on the last slice instead of wrapping.
            if (idx_q != LAST) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): scoreboard of {cout,sum} pushed at accept,
// popped when out_valid is seen; also checks latency, backpressure stability and mid-op reset.
// Define NSA_SUBTRACT_EN to exercise the subtract path.
module tb_nibble_serial_adder;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             busy_o;

    int tests;
    int errs;

    logic [WIDTH:0] sb[$];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
`ifdef NSA_SUBTRACT_EN
        .sub_i     (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .cout_o    (cout_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation; hold>0 keeps out_ready low that many cycles in DONE while in_valid
    // stays high with changing operands.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input int hold);
        int n;
        logic [WIDTH:0] e;
        logic [WIDTH:0] exp_r;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a_i = a; b_i = b; cin_i = c; sub_i = s;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        if (s) e = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   e = {1'b0, a} + {1'b0, b} + {16'd0, c};
        sb.push_back(e);
        @(negedge clk);
        // Busy phase: keep in_valid high with junk operands; must be ignored.
        n = 0;
        while (!out_valid && n < 100) begin
            if (n == 0) check("in_ready_run", {31'd0, in_ready}, 32'd0);
            a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); cin_i = 1'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", n, NSLICE);
        check("busy_done", {31'd0, busy_o}, 32'd1);
        in_valid = (hold > 0);
        exp_r = (sb.size() > 0) ? sb.pop_front() : '1;
        check("sum", {16'd0, sum_o}, {16'd0, exp_r[WIDTH-1:0]});
        check("cout", {31'd0, cout_o}, {31'd0, exp_r[WIDTH]});
        for (int i = 0; i < hold; i++) begin
            a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_sum", {16'd0, sum_o}, {16'd0, exp_r[WIDTH-1:0]});
            check("bp_cout", {31'd0, cout_o}, {31'd0, exp_r[WIDTH]});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", {31'd0, out_valid}, 32'd0);
        check("idle_busy", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_sum"}, {16'd0, sum_o}, 32'd0);
        check({tag, "_cout"}, {31'd0, cout_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        tests = 0; errs = 0;
        rst = 1'b1; in_valid = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        out_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0);

        // Backpressure in DONE, then the next operation must still be accepted.
        run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 5);
        run_op(16'hABCD, 16'h1234, 1'b0, 1'b0, 0);

        // Reset two cycles into RUN with operands that leave non-zero partial sums.
        a_i = 16'hFFFF; b_i = 16'hFFFF; cin_i = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            run_op(ra, rb, rc, 1'b0, k % 3);
        end

`ifdef NSA_SUBTRACT_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
        run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 0);
        run_op(16'h0001, 16'h0001, 1'b1, 1'b0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
